// File: rtl/regfile_wb_arbiter.sv
// Purpose : shares the register-file write port between pipeline writeback and buffered miss returns, and tracks registers still waiting on a miss.
// Latency : pipeline writes pass through combinationally; a queued miss return commits in the first cycle the pipeline leaves the port idle.
// Backpres: ld_ready drops while the return buffer is full. pipe_hold asks the pipeline for one idle cycle after STARVE_MAX starved cycles.
//
// Ports:
//   clk, rst_n                  clock and asynchronous active-low reset
//   wb_valid/wb_rd/wb_data      pipeline writeback; it always takes the port
//   iss_valid/iss_rd            issued load miss; marks iss_rd pending
//   ld_valid/ld_ready/ld_rd/ld_data   miss-return push interface into the buffer
//   rs1, rs2 -> rd_stall        decode source registers and their pending-stall flag
//   pipe_hold                   registered one-cycle request for a pipeline bubble
//   we3/a3/wd3                  register-file write port
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8,
    localparam int AW = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_valid,
    input  logic [AW-1:0]         wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_rd,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [AW-1:0]         ld_rd,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic [AW-1:0]         rs1,
    input  logic [AW-1:0]         rs2,
    output logic                  rd_stall,
    output logic                  pipe_hold,
    output logic                  we3,
    output logic [AW-1:0]         a3,
    output logic [DATA_WIDTH-1:0] wd3
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(STARVE_MAX);

    // Miss-return buffer. The pointers carry one extra bit so that full and empty can be told apart.
    logic [AW-1:0]         rd_mem  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] dat_mem [FIFO_DEPTH];
    logic [PW:0]           wr_ptr, rd_ptr;
    logic                  empty, full, push, pop;
    logic [AW-1:0]         head_rd;
    logic [DATA_WIDTH-1:0] head_dat;

    logic [NUM_REGS-1:0]   pend;
    logic [SW-1:0]         starve_cnt;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign ld_ready = !full;
    // Returns to x0 are discarded here, so no queued entry ever targets x0.
    assign push     = ld_valid && ld_ready && (ld_rd != '0);
    assign head_rd  = rd_mem[rd_ptr[PW-1:0]];
    assign head_dat = dat_mem[rd_ptr[PW-1:0]];

    // Write-port mux. The pipeline always wins, even for an x0 write, because it cannot be stalled.
    always_comb begin
        we3 = 1'b0;
        a3  = '0;
        wd3 = '0;
        pop = 1'b0;
        if (wb_valid) begin
            we3 = (wb_rd != '0);
            a3  = wb_rd;
            wd3 = wb_data;
        end else if (!empty) begin
            we3 = 1'b1;
            a3  = head_rd;
            wd3 = head_dat;
            pop = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr[PW-1:0]]  <= ld_rd;
            dat_mem[wr_ptr[PW-1:0]] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Pending scoreboard. The set is written after the clear, so a new miss to the same register wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            if (pop) pend[head_rd] <= 1'b0;
            if (iss_valid && (iss_rd != '0)) pend[iss_rd] <= 1'b1;
        end
    end

    assign rd_stall = ((rs1 != '0) && pend[rs1]) || ((rs2 != '0) && pend[rs2]);

    // Starvation counter. It counts cycles in which a queued return loses the port to the pipeline.
    // On the STARVE_MAX-th such cycle it raises pipe_hold for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            pipe_hold  <= 1'b0;
        end else begin
            pipe_hold <= 1'b0;
            if (pop || empty) begin
                starve_cnt <= '0;
            end else if (wb_valid) begin
                if (starve_cnt == SW'(STARVE_MAX - 1)) begin
                    starve_cnt <= '0;
                    pipe_hold  <= 1'b1;
                end else begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Purpose : directed test of regfile_wb_arbiter covering the write-port mux, the return buffer, the pending scoreboard, starvation and reset.
// Latency : checks are made 1-2 time units after a posedge, well away from both clock edges.
// Backpres: return pushes are issued only while ld_ready is expected high.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid, iss_valid, ld_valid;
    logic [4:0]  wb_rd, iss_rd, ld_rd, rs1, rs2;
    logic [31:0] wb_data, ld_data;
    logic        ld_ready, rd_stall, pipe_hold, we3;
    logic [4:0]  a3;
    logic [31:0] wd3;

    int tests = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .rs1(rs1), .rs2(rs2), .rd_stall(rd_stall), .pipe_hold(pipe_hold),
        .we3(we3), .a3(a3), .wd3(wd3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; wb_valid = 0; wb_rd = 0; wb_data = 0;
        iss_valid = 0; iss_rd = 0; ld_valid = 0; ld_rd = 0; ld_data = 0;
        rs1 = 0; rs2 = 0;
        #1;
        chk("rst_we3", we3, 0);
        chk("rst_a3", a3, 0);
        chk("rst_wd3", wd3, 0);
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_rd_stall", rd_stall, 0);
        chk("rst_pipe_hold", pipe_hold, 0);
        tick; tick;
        rst_n = 1'b1;
        tick;

        // 1: pipeline writeback passes through in the same cycle; an x0 write is suppressed
        wb_valid = 1; wb_rd = 5; wb_data = 32'hDEADBEEF; #1;
        chk("t1_we3", we3, 1);
        chk("t1_a3", a3, 5);
        chk("t1_wd3", wd3, 32'hDEADBEEF);
        wb_rd = 0; #1;
        chk("t1_x0_we3", we3, 0);
        wb_valid = 0; wb_rd = 0; wb_data = 0;
        tick;

        // 2: scoreboard set, stall, return, clear
        iss_valid = 1; iss_rd = 10; rs1 = 10; #1;
        chk("t2_stall_before", rd_stall, 0);
        tick;
        iss_valid = 0; iss_rd = 0; #1;
        chk("t2_stall_rs1", rd_stall, 1);
        rs1 = 0; rs2 = 10; #1;
        chk("t2_stall_rs2", rd_stall, 1);
        ld_valid = 1; ld_rd = 10; ld_data = 32'h42;
        tick;
        ld_valid = 0; ld_rd = 0; ld_data = 0; #1;
        chk("t2_we3", we3, 1);
        chk("t2_a3", a3, 10);
        chk("t2_wd3", wd3, 32'h42);
        chk("t2_stall_held", rd_stall, 1);
        tick;
        chk("t2_stall_clr", rd_stall, 0);
        chk("t2_idle_we3", we3, 0);
        rs2 = 0;

        // 3: fill the buffer while the pipeline keeps the port busy
        wb_valid = 1; wb_rd = 1; wb_data = 32'h1111;
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1; ld_rd = 5'(11 + i); ld_data = 32'hA0 + i; #1;
            chk("t3_ready_pre", ld_ready, 1);
            tick;
        end
        ld_valid = 0; ld_rd = 0; ld_data = 0; #1;
        chk("t3_full", ld_ready, 0);
        chk("t3_a3_pipe", a3, 1);
        chk("t3_wd3_pipe", wd3, 32'h1111);

        // 4: three starved cycles have elapsed; five more raise pipe_hold
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("t4_no_hold", pipe_hold, 0);
        end
        tick;
        chk("t4_hold", pipe_hold, 1);
        wb_valid = 0; wb_rd = 0; wb_data = 0; #1;
        chk("t4_head_we3", we3, 1);
        chk("t4_head_a3", a3, 11);
        chk("t4_head_wd3", wd3, 32'hA0);
        tick;
        chk("t4_hold_one", pipe_hold, 0);
        chk("t4_next_a3", a3, 12);
        chk("t4_next_wd3", wd3, 32'hA1);
        chk("t4_ready", ld_ready, 1);
        tick; tick; tick;
        chk("t4_drained", we3, 0);

        // 5: a set to the same register in the same cycle as its clear wins; an x0 return is dropped
        iss_valid = 1; iss_rd = 3;
        tick;
        iss_valid = 0; iss_rd = 0;
        ld_valid = 1; ld_rd = 3; ld_data = 32'h33;
        tick;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        iss_valid = 1; iss_rd = 3; #1;
        chk("t5_commit_a3", a3, 3);
        tick;
        iss_valid = 0; iss_rd = 0; rs1 = 3; #1;
        chk("t5_set_wins", rd_stall, 1);
        chk("t5_popped", we3, 0);
        rs1 = 0;
        ld_valid = 1; ld_rd = 0; ld_data = 32'h99; #1;
        chk("t5_x0_ready", ld_ready, 1);
        tick;
        ld_valid = 0; ld_data = 0; #1;
        chk("t5_x0_not_queued", we3, 0);
        chk("t5_x0_ready_after", ld_ready, 1);

        // 6: reset taken mid-operation discards queued returns and all pending bits
        iss_valid = 1; iss_rd = 7;
        tick;
        iss_valid = 0; iss_rd = 0;
        wb_valid = 1; wb_rd = 2; wb_data = 32'h2;
        ld_valid = 1; ld_rd = 20; ld_data = 32'h20;
        tick;
        ld_rd = 21; ld_data = 32'h21;
        tick;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        wb_valid = 0; wb_rd = 0; wb_data = 0; rs1 = 7; #1;
        chk("t6_pre_we3", we3, 1);
        chk("t6_pre_a3", a3, 20);
        chk("t6_pre_stall", rd_stall, 1);
        rst_n = 1'b0; #1;
        chk("t6_rst_ready", ld_ready, 1);
        chk("t6_rst_we3", we3, 0);
        chk("t6_rst_stall", rd_stall, 0);
        tick;
        rst_n = 1'b1;
        tick;
        chk("t6_post_we3", we3, 0);
        chk("t6_post_stall", rd_stall, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
